// File: rtl/rk_pingpong_buffer.sv
// Two-bank ping-pong store for rK / rKold residual blocks with per-entry valid tracking.
// Latency: read_latency (1 or 2) cycles from rd_en to rd_valid; writes land on the issuing edge.
// Backpressure: none; accepts one write and one read per cycle, never stalls.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   wr_en     write one block into the write bank (bank ~bank_sel)
//   wr_addr   block address for the write
//   wr_data   rK block, no_of_units lanes of element_width bits
//   rd_en     read one block from the read bank (bank bank_sel)
//   rd_addr   block address for the read
//   swap      one-cycle pulse at the iteration boundary: exchange banks
//   clear     synchronous clear of all valid bits, bank_sel and wr_count
//   rd_data   rKold block, holds its last value between reads
//   rd_valid  a read retires this cycle
//   rd_stale  qualifies rd_valid: entry not written since its bank last became the write bank
//   bank_sel  current read bank; the write bank is ~bank_sel
//   wr_count  writes accepted into the write bank since the last swap/clear (saturates at depth)
//   addr_err  sticky flag: an out-of-range wr_addr or rd_addr was presented
module rk_pingpong_buffer #(
  parameter int no_of_units   = 8,
  parameter int element_width = 32,
  parameter int depth         = 95,
  parameter int addr_width    = 7,
  parameter int read_latency  = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   wr_en,
  input  logic [addr_width-1:0]                  wr_addr,
  input  logic [no_of_units*element_width-1:0]   wr_data,
  input  logic                                   rd_en,
  input  logic [addr_width-1:0]                  rd_addr,
  input  logic                                   swap,
  input  logic                                   clear,
  output logic [no_of_units*element_width-1:0]   rd_data,
  output logic                                   rd_valid,
  output logic                                   rd_stale,
  output logic                                   bank_sel,
  output logic [addr_width:0]                    wr_count,
  output logic                                   addr_err
);

  localparam int                block_width = no_of_units * element_width;
  localparam logic [addr_width:0] depth_c   = (addr_width + 1)'(depth);
  localparam logic [addr_width:0] one_c     = (addr_width + 1)'(1);

  // Block storage; contents are deliberately not reset.
  logic [block_width-1:0] mem0 [depth];
  logic [block_width-1:0] mem1 [depth];

  // valid0/valid1: entry written since that bank last became the write bank.
  logic [depth-1:0] valid0;
  logic [depth-1:0] valid1;

  logic wr_in_range;
  logic rd_in_range;
  logic wr_accept;
  logic wr_bank;

  // First read stage: bank and stale state captured on the issue edge.
  logic                   s1_vld;
  logic [block_width-1:0] s1_dat;
  logic                   s1_stale;

  always_comb begin
    wr_in_range = ({1'b0, wr_addr} < depth_c);
    rd_in_range = ({1'b0, rd_addr} < depth_c);
    wr_bank     = ~bank_sel;
    // clear discards a same-cycle write entirely, data included.
    wr_accept   = wr_en && wr_in_range && !clear;
  end

  // RAM write port. The write bank is always the opposite of the read bank,
  // so a same-address read in the same cycle never sees this write.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      if (wr_bank) begin
        mem1[wr_addr] <= wr_data;
      end else begin
        mem0[wr_addr] <= wr_data;
      end
    end
  end

  // Bank select, valid tracking, write counter and sticky address error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_sel <= 1'b0;
      valid0   <= '0;
      valid1   <= '0;
      wr_count <= '0;
      addr_err <= 1'b0;
    end else begin
      // addr_err is only ever cleared by reset, clear does not touch it.
      if ((wr_en && !wr_in_range) || (rd_en && !rd_in_range)) begin
        addr_err <= 1'b1;
      end

      if (clear) begin
        bank_sel <= 1'b0;
        valid0   <= '0;
        valid1   <= '0;
        wr_count <= '0;
      end else begin
        // A write coinciding with swap goes to the pre-swap write bank and
        // stays valid: that bank becomes the read bank after this edge.
        if (wr_accept) begin
          if (wr_bank) begin
            valid1[wr_addr] <= 1'b1;
          end else begin
            valid0[wr_addr] <= 1'b1;
          end
        end

        if (swap) begin
          bank_sel <= ~bank_sel;
          // The outgoing read bank becomes the new write bank: its contents
          // are now from an earlier iteration.
          if (bank_sel) begin
            valid1 <= '0;
          end else begin
            valid0 <= '0;
          end
          wr_count <= '0;
        end else if (wr_accept && (wr_count != depth_c)) begin
          wr_count <= wr_count + one_c;
        end
      end
    end
  end

  // Read issue stage. bank_sel is sampled here, so a read issued with swap
  // (or with clear) still uses the pre-edge bank and valid state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld   <= 1'b0;
      s1_dat   <= '0;
      s1_stale <= 1'b0;
    end else begin
      s1_vld <= rd_en;
      if (rd_en) begin
        if (!rd_in_range) begin
          s1_dat   <= '0;
          s1_stale <= 1'b1;
        end else if (bank_sel) begin
          s1_dat   <= mem1[rd_addr];
          s1_stale <= ~valid1[rd_addr];
        end else begin
          s1_dat   <= mem0[rd_addr];
          s1_stale <= ~valid0[rd_addr];
        end
      end
    end
  end

  // Output stage. Any read_latency other than 2 behaves as latency 1.
  generate
    if (read_latency == 2) begin : g_lat2
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rd_valid <= 1'b0;
          rd_data  <= '0;
          rd_stale <= 1'b0;
        end else begin
          rd_valid <= s1_vld;
          if (s1_vld) begin
            rd_data  <= s1_dat;
            rd_stale <= s1_stale;
          end
        end
      end
    end else begin : g_lat1
      assign rd_valid = s1_vld;
      assign rd_data  = s1_dat;
      assign rd_stale = s1_stale;
    end
  endgenerate

endmodule

// File: tb/tb_rk_pingpong_buffer.sv
// Self-checking bench for rk_pingpong_buffer, latency-1 and latency-2 instances on shared stimulus.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; the DUT never stalls.
module tb_rk_pingpong_buffer;

  localparam int AW = 7;
  localparam int BW = 256;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [BW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          swap;
  logic          clear;

  logic [BW-1:0] rd_data1,  rd_data2;
  logic          rd_valid1, rd_valid2;
  logic          rd_stale1, rd_stale2;
  logic          bank_sel1, bank_sel2;
  logic [AW:0]   wr_count1, wr_count2;
  logic          addr_err1, addr_err2;

  int n_tests;
  int n_fail;

  rk_pingpong_buffer #(.read_latency(1)) dut1 (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .swap(swap), .clear(clear),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_stale(rd_stale1),
    .bank_sel(bank_sel1), .wr_count(wr_count1), .addr_err(addr_err1)
  );

  rk_pingpong_buffer #(.read_latency(2)) dut2 (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .swap(swap), .clear(clear),
    .rd_data(rd_data2), .rd_valid(rd_valid2), .rd_stale(rd_stale2),
    .bank_sel(bank_sel2), .wr_count(wr_count2), .addr_err(addr_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [BW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          swap;
    logic          clear;
    logic          e_vld;
    logic          chk_dat;
    logic [BW-1:0] e_dat;
    logic          e_stale;
    logic          e_bank;
    logic [AW:0]   e_cnt;
    logic          e_err;
  } vec_t;

  // Block pattern: lane k holds a*256 + k + salt.
  function automatic logic [BW-1:0] blk(input int a, input int salt);
    logic [BW-1:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = 32'(a * 256 + k + salt);
    return r;
  endfunction

  function automatic vec_t mk(input int we, input int wa, input logic [BW-1:0] wd,
                              input int re, input int ra, input int sw, input int cl,
                              input int ev, input int cd, input logic [BW-1:0] ed,
                              input int es, input int eb, input int ec, input int ee);
    vec_t v;
    v.wr_en = 1'(we);   v.wr_addr = AW'(wa); v.wr_data = wd;
    v.rd_en = 1'(re);   v.rd_addr = AW'(ra); v.swap = 1'(sw); v.clear = 1'(cl);
    v.e_vld = 1'(ev);   v.chk_dat = 1'(cd);  v.e_dat = ed;   v.e_stale = 1'(es);
    v.e_bank = 1'(eb);  v.e_cnt = (AW + 1)'(ec); v.e_err = 1'(ee);
    return v;
  endfunction

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chkc(input string nm, input logic [AW:0] act, input logic [AW:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; swap = 1'b0; clear = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t          vecs [14];
  logic          obs_vld1 [11], obs_vld2 [11];
  logic          obs_st2  [11];
  logic [BW-1:0] obs_dat1 [11], obs_dat2 [11];

  initial begin
    int pulses;
    n_tests = 0;
    n_fail  = 0;
    idle();
    reset = 1'b0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    chkb("rst_rd_valid1", rd_valid1, 1'b0);
    chkb("rst_rd_valid2", rd_valid2, 1'b0);
    chkd("rst_rd_data1", rd_data1, '0);
    chkd("rst_rd_data2", rd_data2, '0);
    chkb("rst_rd_stale1", rd_stale1, 1'b0);
    chkb("rst_bank_sel1", bank_sel1, 1'b0);
    chkc("rst_wr_count1", wr_count1, '0);
    chkb("rst_addr_err1", addr_err1, 1'b0);
    reset = 1'b1;
    step();

    // ---- 1) fill write bank, saturate count, swap, read everything back ----
    for (int a = 0; a < 95; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = blk(a, 0);
      step();
      chkc($sformatf("t1_wr_count[%0d]", a), wr_count1, (AW + 1)'(a + 1));
    end
    wr_addr = '0; wr_data = blk(0, 0);
    step();
    chkc("t1_wr_count_sat", wr_count1, 8'd95);
    idle();
    swap = 1'b1;
    step();
    chkb("t1_bank_sel", bank_sel1, 1'b1);
    chkc("t1_wr_count_swap", wr_count1, '0);
    swap = 1'b0;
    for (int a = 0; a < 95; a++) begin
      rd_en = 1'b1; rd_addr = AW'(a);
      step();
      chkb($sformatf("t1_rd_valid[%0d]", a), rd_valid1, 1'b1);
      chkd($sformatf("t1_rd_data[%0d]", a), rd_data1, blk(a, 0));
      chkb($sformatf("t1_rd_stale[%0d]", a), rd_stale1, 1'b0);
    end
    idle();
    step();
    chkb("t1_rd_valid_idle", rd_valid1, 1'b0);
    chkd("t1_rd_data_hold", rd_data1, blk(94, 0));

    // ---- 2,3,5 + clear: table-driven vectors, latency-1 instance ----
    //             we wa  wd                  re ra  sw cl  ev cd ed               es eb cnt err
    vecs[0]  = mk(0, 0,  '0,                 1, 3,  0, 0,  1, 1, blk(3, 0),       0, 1, 0, 0);
    vecs[1]  = mk(0, 0,  '0,                 0, 0,  1, 0,  0, 0, '0,              0, 0, 0, 0);
    vecs[2]  = mk(0, 0,  '0,                 1, 3,  0, 0,  1, 0, '0,              1, 0, 0, 0);
    vecs[3]  = mk(1, 5,  256'hA5,            0, 0,  1, 0,  0, 0, '0,              0, 1, 0, 0);
    vecs[4]  = mk(0, 0,  '0,                 1, 5,  0, 0,  1, 1, 256'hA5,         0, 1, 0, 0);
    vecs[5]  = mk(0, 0,  '0,                 1, 6,  0, 0,  1, 1, blk(6, 0),       1, 1, 0, 0);
    vecs[6]  = mk(1, 7,  blk(7, 'h30000),    1, 7,  0, 0,  1, 1, blk(7, 0),       1, 1, 1, 0);
    vecs[7]  = mk(1, 7,  blk(7, 'h40000),    0, 0,  0, 0,  0, 1, blk(7, 0),       0, 1, 2, 0);
    vecs[8]  = mk(1, 100, blk(9, 9),         1, 127, 0, 0, 1, 1, '0,              1, 1, 2, 1);
    vecs[9]  = mk(0, 0,  '0,                 0, 0,  0, 0,  0, 0, '0,              0, 1, 2, 1);
    vecs[10] = mk(1, 7,  blk(7, 'h50000),    0, 0,  0, 1,  0, 0, '0,              0, 0, 0, 1);
    vecs[11] = mk(0, 0,  '0,                 1, 7,  0, 0,  1, 1, blk(7, 'h40000), 1, 0, 0, 1);
    vecs[12] = mk(0, 0,  '0,                 0, 0,  1, 0,  0, 0, '0,              0, 1, 0, 1);
    vecs[13] = mk(0, 0,  '0,                 1, 8,  0, 0,  1, 1, blk(8, 0),       1, 1, 0, 1);

    for (int i = 0; i < 14; i++) begin
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr;
      swap  = vecs[i].swap;  clear   = vecs[i].clear;
      step();
      chkb($sformatf("vec%0d_rd_valid", i), rd_valid1, vecs[i].e_vld);
      chkb($sformatf("vec%0d_bank_sel", i), bank_sel1, vecs[i].e_bank);
      chkc($sformatf("vec%0d_wr_count", i), wr_count1, vecs[i].e_cnt);
      chkb($sformatf("vec%0d_addr_err", i), addr_err1, vecs[i].e_err);
      if (vecs[i].chk_dat) chkd($sformatf("vec%0d_rd_data", i), rd_data1, vecs[i].e_dat);
      if (vecs[i].e_vld)   chkb($sformatf("vec%0d_rd_stale", i), rd_stale1, vecs[i].e_stale);
    end
    idle();

    // ---- 4) back-to-back reads with swap on the 3rd, latency-2 instance ----
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int a = 0; a < 8; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = blk(a, 'h10000);
      step();
    end
    idle();
    swap = 1'b1;
    step();
    swap = 1'b0;
    for (int a = 0; a < 8; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = blk(a, 'h20000);
      step();
    end
    idle();
    for (int j = 0; j < 11; j++) begin
      rd_en = (j < 8); rd_addr = AW'(j); swap = (j == 2);
      step();
      obs_vld1[j] = rd_valid1; obs_dat1[j] = rd_data1;
      obs_vld2[j] = rd_valid2; obs_dat2[j] = rd_data2; obs_st2[j] = rd_stale2;
    end
    idle();
    pulses = 0;
    for (int j = 0; j < 11; j++) begin
      if (obs_vld2[j]) pulses++;
      chkb($sformatf("t4_lat2_valid[%0d]", j), obs_vld2[j], (j >= 1 && j <= 8));
      chkb($sformatf("t4_lat1_valid[%0d]", j), obs_vld1[j], (j < 8));
      if (j >= 1 && j <= 8) begin
        chkd($sformatf("t4_lat2_data[%0d]", j - 1), obs_dat2[j],
             (j - 1 < 3) ? blk(j - 1, 'h10000) : blk(j - 1, 'h20000));
        chkb($sformatf("t4_lat2_stale[%0d]", j - 1), obs_st2[j], 1'b0);
      end
      if (j < 8)
        chkd($sformatf("t4_lat1_data[%0d]", j), obs_dat1[j],
             (j < 3) ? blk(j, 'h10000) : blk(j, 'h20000));
    end
    n_tests++;
    if (pulses != 8) begin
      n_fail++;
      $display("FAIL t4_pulse_count: got %0d expected 8", pulses);
    end

    // ---- 6) reset while reads are in flight ----
    rd_en = 1'b1; rd_addr = AW'(1);
    step();
    idle();
    chkb("t6_pre_rst_valid1", rd_valid1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chkb("t6_rst_valid1_now", rd_valid1, 1'b0);
    chkb("t6_rst_valid2_now", rd_valid2, 1'b0);
    chkd("t6_rst_data1_now", rd_data1, '0);
    step();
    reset = 1'b1;
    step();
    chkb("t6_inflight_lost2", rd_valid2, 1'b0);
    chkb("t6_bank_sel", bank_sel1, 1'b0);
    chkc("t6_wr_count", wr_count1, '0);
    chkb("t6_addr_err", addr_err1, 1'b0);
    rd_en = 1'b1; rd_addr = AW'(0);
    step();
    chkb("t6_rd0_valid", rd_valid1, 1'b1);
    chkb("t6_rd0_stale", rd_stale1, 1'b1);
    chkd("t6_rd0_data", rd_data1, blk(0, 'h20000));
    rd_addr = AW'(4);
    step();
    idle();
    chkb("t6_rd4_stale", rd_stale1, 1'b1);
    chkd("t6_rd4_data", rd_data1, blk(4, 'h20000));
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
